// File: rtl/isp_pkg.sv
// Shared ISP definitions: default pixel width, Bayer {y,x} parity codes and
// the mosaic sequencer state type.
package isp_pkg;

  localparam int DW_DEF = 10;

  localparam logic [1:0] CODE_B  = 2'd0;
  localparam logic [1:0] CODE_GB = 2'd1;
  localparam logic [1:0] CODE_GR = 2'd2;
  localparam logic [1:0] CODE_R  = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } mosaic_state_e;

  // Counter width for a range of n positions, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bayer_pos_cnt.sv
// Column/row position tracker for the mosaic: derives Bayer parity of the
// current pixel, line/frame end and the EOL consistency check.
module bayer_pos_cnt
  import isp_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X0    = 1,
  parameter int Y0    = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic adv_i,
  input  logic sof_i,
  input  logic eol_i,
  output logic x_o,
  output logic y_o,
  output logic line_end_o,
  output logic frame_end_o,
  output logic eol_err_o,
  output logic at_origin_o
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic X0_B = X0[0];
  localparam logic Y0_B = Y0[0];

  logic [CW-1:0] col_q, col_d, pos_col_s;
  logic [RW-1:0] row_q, row_d, pos_row_s;
  logic          col_last_s;

  // SOF forces the current pixel to (0,0) before any EOL evaluation.
  always_comb begin
    pos_col_s   = sof_i ? {CW{1'b0}} : col_q;
    pos_row_s   = sof_i ? {RW{1'b0}} : row_q;
    col_last_s  = (pos_col_s == COL_LAST);
    line_end_o  = col_last_s || eol_i;
    frame_end_o = line_end_o && (pos_row_s == ROW_LAST);
    eol_err_o   = eol_i ^ col_last_s;
    at_origin_o = (col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}});
    x_o         = pos_col_s[0] ^ X0_B;
    y_o         = pos_row_s[0] ^ Y0_B;
    col_d       = col_q;
    row_d       = row_q;
    if (adv_i) begin
      if (line_end_o) begin
        col_d = {CW{1'b0}};
        row_d = frame_end_o ? {RW{1'b0}} : pos_row_s + RW'(1);
      end else begin
        col_d = pos_col_s + CW'(1);
        row_d = pos_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      col_q <= {CW{1'b0}};
      row_q <= {RW{1'b0}};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/rgb_raw_mosaic.sv
// RGB to Bayer RAW mosaic: picks one component per pixel by {y,x} parity and
// forwards it through a single-entry valid/ready output register.
module rgb_raw_mosaic
  import isp_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X0    = 1,
  parameter int Y0    = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] S_R,
  input  logic [DW-1:0] S_G,
  input  logic [DW-1:0] S_B,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic          S_SOF,
  input  logic          S_EOL,
  output logic [DW-1:0] M_DATA,
  output logic          M_X,
  output logic          M_Y,
  output logic          M_SOF,
  output logic          M_EOL,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic          ERR_SYNC
);

  mosaic_state_e state_q, state_d;
  logic [DW-1:0] m_data_q, m_data_d, pix_s;
  logic          m_x_q, m_x_d, m_y_q, m_y_d;
  logic          m_sof_q, m_sof_d, m_eol_q, m_eol_d;
  logic          m_valid_q, m_valid_d, err_q, err_d;
  logic          acc_s, emit_s, sof_err_s;
  logic          x_s, y_s, line_end_s, frame_end_s, eol_err_s, at_origin_s;

  assign S_READY  = !m_valid_q || M_READY;
  assign M_DATA   = m_data_q;
  assign M_X      = m_x_q;
  assign M_Y      = m_y_q;
  assign M_SOF    = m_sof_q;
  assign M_EOL    = m_eol_q;
  assign M_VALID  = m_valid_q;
  assign ERR_SYNC = err_q;

  bayer_pos_cnt #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .X0   (X0),
    .Y0   (Y0)
  ) u_pos (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .adv_i      (emit_s),
    .sof_i      (S_SOF),
    .eol_i      (S_EOL),
    .x_o        (x_s),
    .y_o        (y_s),
    .line_end_o (line_end_s),
    .frame_end_o(frame_end_s),
    .eol_err_o  (eol_err_s),
    .at_origin_o(at_origin_s)
  );

  // Sequencer next state, component select and output register load.
  always_comb begin
    acc_s     = S_VALID && S_READY;
    // IDLE swallows pixels until a frame start shows up.
    emit_s    = acc_s && (S_SOF || (state_q == ST_ACTIVE));
    sof_err_s = (state_q == ST_ACTIVE) && S_SOF && !at_origin_s;
    err_d     = err_q || (emit_s && (eol_err_s || sof_err_s));
    state_d   = state_q;
    if (emit_s) begin
      state_d = frame_end_s ? ST_IDLE : ST_ACTIVE;
    end else begin
      state_d = state_q;
    end

    case ({y_s, x_s})
      CODE_R:  pix_s = S_R;
      CODE_B:  pix_s = S_B;
      CODE_GB: pix_s = S_G;
      CODE_GR: pix_s = S_G;
      default: pix_s = S_G;
    endcase

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_x_d     = m_x_q;
    m_y_d     = m_y_q;
    m_sof_d   = m_sof_q;
    m_eol_d   = m_eol_q;
    if (S_READY) begin
      m_valid_d = emit_s;
      if (emit_s) begin
        m_data_d = pix_s;
        m_x_d    = x_s;
        m_y_d    = y_s;
        m_sof_d  = S_SOF;
        m_eol_d  = line_end_s;
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State, output and sticky error registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= {DW{1'b0}};
      m_x_q     <= 1'b0;
      m_y_q     <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_x_q     <= m_x_d;
      m_y_q     <= m_y_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rgb_raw_mosaic.sv
// Scoreboard bench for rgb_raw_mosaic on a 4x2 image (RGGB and BGGR phases).
module tb_rgb_raw_mosaic;
  import isp_pkg::*;

  typedef struct packed {
    logic [9:0] d;
    logic [1:0] c;
    logic       sof;
    logic       eol;
  } exp_t;

  localparam logic [9:0] PR = 10'd100;
  localparam logic [9:0] PG = 10'd200;
  localparam logic [9:0] PB = 10'd300;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [9:0] S_R, S_G, S_B;
  logic       S_VALID, S_READY, S_SOF, S_EOL;
  logic [9:0] M_DATA;
  logic       M_X, M_Y, M_SOF, M_EOL, M_VALID, M_READY, ERR_SYNC;

  logic       z_s_valid, z_s_ready, z_s_sof, z_s_eol;
  logic [9:0] z_m_data;
  logic       z_m_x, z_m_y, z_m_sof, z_m_eol, z_m_valid, z_m_ready, z_err;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t zq[$];

  always #5 CLK = ~CLK;

  rgb_raw_mosaic #(.DW(10), .IMG_W(4), .IMG_H(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_R(S_R), .S_G(S_G), .S_B(S_B),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_SOF(S_SOF), .S_EOL(S_EOL),
    .M_DATA(M_DATA), .M_X(M_X), .M_Y(M_Y), .M_SOF(M_SOF), .M_EOL(M_EOL),
    .M_VALID(M_VALID), .M_READY(M_READY), .ERR_SYNC(ERR_SYNC)
  );

  rgb_raw_mosaic #(.DW(10), .IMG_W(4), .IMG_H(2), .X0(0), .Y0(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .S_R(S_R), .S_G(S_G), .S_B(S_B),
    .S_VALID(z_s_valid), .S_READY(z_s_ready), .S_SOF(z_s_sof), .S_EOL(z_s_eol),
    .M_DATA(z_m_data), .M_X(z_m_x), .M_Y(z_m_y), .M_SOF(z_m_sof), .M_EOL(z_m_eol),
    .M_VALID(z_m_valid), .M_READY(z_m_ready), .ERR_SYNC(z_err)
  );

  function automatic exp_t mk(input logic [9:0] d, input logic [1:0] c,
                              input logic s, input logic e);
    return {d, c, s, e};
  endfunction

  task automatic drive_pix(input logic v, input logic sof, input logic eol);
    S_VALID = v;
    S_SOF   = v && sof;
    S_EOL   = v && eol;
  endtask

  task automatic test_reset();
    RST_N   = 1'b0;
    M_READY = 1'b0;
    drive_pix(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if ({M_VALID, M_DATA, M_X, M_Y, M_SOF, M_EOL, ERR_SYNC} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0",
               {M_VALID, M_DATA, M_X, M_Y, M_SOF, M_EOL, ERR_SYNC});
    end
    n_chk++;
    if (S_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_s_ready got %b exp 1", S_READY);
    end
    RST_N   = 1'b1;
    M_READY = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_pre_sof();
    for (int k = 0; k < 5; k++) begin
      drive_pix(1'b1, 1'b0, k == 3);
      #1;
      n_chk++;
      if (M_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_sof_valid[%0d] got %b exp 0", k, M_VALID);
      end
      @(posedge CLK);
      #1;
    end
    drive_pix(1'b0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if ({M_VALID, ERR_SYNC} !== 2'b00) begin
      n_fail++;
      $display("FAIL pre_sof_end got valid=%b err=%b exp 0 0", M_VALID, ERR_SYNC);
    end
    @(posedge CLK);
    #1;
  endtask

  // Full frame; stall_at >= 0 holds M_READY low for 3 cycles from that cycle.
  task automatic test_frame(input int stall_at);
    exp_t tbl[8];
    exp_t e;
    int   i;
    tbl = '{mk(PR, 2'd3, 1'b1, 1'b0), mk(PG, 2'd2, 1'b0, 1'b0),
            mk(PR, 2'd3, 1'b0, 1'b0), mk(PG, 2'd2, 1'b0, 1'b1),
            mk(PG, 2'd1, 1'b0, 1'b0), mk(PB, 2'd0, 1'b0, 1'b0),
            mk(PG, 2'd1, 1'b0, 1'b0), mk(PB, 2'd0, 1'b0, 1'b1)};
    i = 0;
    for (int cyc = 0; cyc < 40 && (i < 8 || q.size() > 0); cyc++) begin
      drive_pix(i < 8, i == 0, i == 3 || i == 7);
      M_READY = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      #1;
      if (!M_READY) begin
        n_chk++;
        if (S_READY !== 1'b0 || M_VALID !== 1'b1 || q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_hold[%0d] got s_ready=%b m_valid=%b exp 0 1", cyc, S_READY, M_VALID);
        end else if ({M_DATA, M_Y, M_X, M_SOF, M_EOL} !== q[0]) begin
          n_fail++;
          $display("FAIL stall_frozen[%0d] got %h exp %h", cyc,
                   {M_DATA, M_Y, M_X, M_SOF, M_EOL}, q[0]);
        end
      end
      if (M_VALID && M_READY) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_extra got %h exp none", {M_DATA, M_Y, M_X, M_SOF, M_EOL});
        end else begin
          e = q.pop_front();
          if ({M_DATA, M_Y, M_X, M_SOF, M_EOL} !== e) begin
            n_fail++;
            $display("FAIL frame_out[%0d] got %h exp %h", cyc,
                     {M_DATA, M_Y, M_X, M_SOF, M_EOL}, e);
          end
        end
      end
      if (S_VALID && S_READY) begin
        q.push_back(tbl[i]);
        i++;
      end
      @(posedge CLK);
      #1;
    end
    drive_pix(1'b0, 1'b0, 1'b0);
    M_READY = 1'b1;
    #1;
    n_chk++;
    if (i != 8 || q.size() != 0 || M_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done got sent=%0d pending=%0d valid=%b exp 8 0 0", i, q.size(), M_VALID);
    end
    n_chk++;
    if (dut.state_q !== ST_IDLE || ERR_SYNC !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_idle got state=%b err=%b exp 0 0", dut.state_q, ERR_SYNC);
    end
    q.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_early_eol();
    exp_t tbl[7];
    exp_t e;
    int   i;
    tbl = '{mk(PR, 2'd3, 1'b1, 1'b0), mk(PG, 2'd2, 1'b0, 1'b0),
            mk(PR, 2'd3, 1'b0, 1'b1), mk(PG, 2'd1, 1'b0, 1'b0),
            mk(PB, 2'd0, 1'b0, 1'b0), mk(PG, 2'd1, 1'b0, 1'b0),
            mk(PB, 2'd0, 1'b0, 1'b1)};
    i = 0;
    M_READY = 1'b1;
    for (int cyc = 0; cyc < 40 && (i < 7 || q.size() > 0); cyc++) begin
      drive_pix(i < 7, i == 0, i == 2 || i == 6);
      #1;
      if (M_VALID && M_READY) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL eol_extra got %h exp none", {M_DATA, M_Y, M_X, M_SOF, M_EOL});
        end else begin
          e = q.pop_front();
          if ({M_DATA, M_Y, M_X, M_SOF, M_EOL} !== e) begin
            n_fail++;
            $display("FAIL eol_out[%0d] got %h exp %h", cyc,
                     {M_DATA, M_Y, M_X, M_SOF, M_EOL}, e);
          end
        end
      end
      if (S_VALID && S_READY) begin
        q.push_back(tbl[i]);
        i++;
      end
      @(posedge CLK);
      #1;
    end
    drive_pix(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (i != 7 || q.size() != 0 || ERR_SYNC !== 1'b1) begin
      n_fail++;
      $display("FAIL eol_err got sent=%0d pending=%0d err=%b exp 7 0 1", i, q.size(), ERR_SYNC);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if (ERR_SYNC !== 1'b1) begin
      n_fail++;
      $display("FAIL eol_err_sticky got %b exp 1", ERR_SYNC);
    end
    q.delete();
  endtask

  task automatic test_reset_mid();
    exp_t tbl[5];
    exp_t e;
    int   i;
    tbl = '{mk(PR, 2'd3, 1'b1, 1'b0), mk(PG, 2'd2, 1'b0, 1'b0),
            mk(PR, 2'd3, 1'b0, 1'b0), mk(PG, 2'd2, 1'b0, 1'b1),
            mk(PG, 2'd1, 1'b0, 1'b0)};
    i = 0;
    M_READY = 1'b1;
    for (int cyc = 0; cyc < 20 && i < 5; cyc++) begin
      drive_pix(1'b1, i == 0, i == 3);
      #1;
      if (M_VALID && M_READY) begin
        n_chk++;
        e = (q.size() > 0) ? q.pop_front() : '0;
        if ({M_DATA, M_Y, M_X, M_SOF, M_EOL} !== e) begin
          n_fail++;
          $display("FAIL rmid_out[%0d] got %h exp %h", cyc, {M_DATA, M_Y, M_X, M_SOF, M_EOL}, e);
        end
      end
      if (S_VALID && S_READY) begin
        q.push_back(tbl[i]);
        i++;
      end
      @(posedge CLK);
      #1;
    end
    drive_pix(1'b0, 1'b0, 1'b0);
    M_READY = 1'b0;
    #1;
    n_chk++;
    if (M_VALID !== 1'b1 || q.size() != 1 || {M_DATA, M_Y, M_X, M_SOF, M_EOL} !== tbl[4]) begin
      n_fail++;
      $display("FAIL rmid_stalled got valid=%b out=%h exp 1 %h", M_VALID,
               {M_DATA, M_Y, M_X, M_SOF, M_EOL}, tbl[4]);
    end
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    q.delete();
    n_chk++;
    if ({M_VALID, M_DATA, M_X, M_Y, M_SOF, M_EOL, ERR_SYNC} !== 16'h0 || S_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_cleared got %h ready=%b exp 0 1",
               {M_VALID, M_DATA, M_X, M_Y, M_SOF, M_EOL, ERR_SYNC}, S_READY);
    end
    M_READY = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_xy0();
    exp_t tbl[4];
    exp_t e;
    int   i;
    tbl = '{mk(PB, 2'd0, 1'b1, 1'b0), mk(PG, 2'd1, 1'b0, 1'b0),
            mk(PB, 2'd0, 1'b0, 1'b0), mk(PG, 2'd1, 1'b0, 1'b1)};
    i = 0;
    z_m_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && (i < 4 || zq.size() > 0); cyc++) begin
      z_s_valid = (i < 4);
      z_s_sof   = (i == 0);
      z_s_eol   = (i == 3);
      #1;
      if (z_m_valid && z_m_ready) begin
        n_chk++;
        e = (zq.size() > 0) ? zq.pop_front() : '0;
        if ({z_m_data, z_m_y, z_m_x, z_m_sof, z_m_eol} !== e) begin
          n_fail++;
          $display("FAIL xy0_out[%0d] got %h exp %h", cyc,
                   {z_m_data, z_m_y, z_m_x, z_m_sof, z_m_eol}, e);
        end
      end
      if (z_s_valid && z_s_ready) begin
        zq.push_back(tbl[i]);
        i++;
      end
      @(posedge CLK);
      #1;
    end
    z_s_valid = 1'b0;
    n_chk++;
    if (i != 4 || zq.size() != 0) begin
      n_fail++;
      $display("FAIL xy0_done got sent=%0d pending=%0d exp 4 0", i, zq.size());
    end
  endtask

  initial begin
    S_R = PR;
    S_G = PG;
    S_B = PB;
    z_s_valid = 1'b0;
    z_s_sof   = 1'b0;
    z_s_eol   = 1'b0;
    z_m_ready = 1'b1;
    test_reset();
    test_pre_sof();
    test_frame(-1);
    test_frame(3);
    test_early_eol();
    test_reset_mid();
    test_frame(-1);
    test_xy0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_raw_mosaic.md
RGB_RAW_MOSAIC -- requirements
Module: rgb_raw_mosaic

Interface
REQ-001 SHALL have parameter DW, default 10, meaning pixel component width.
REQ-002 SHALL have parameter IMG_W, default 640, meaning active pixels per line.
REQ-003 SHALL have parameter IMG_H, default 480, meaning active lines per frame.
REQ-004 SHALL have parameter X0, default 1, meaning column-parity offset of pixel (0,0).
REQ-005 SHALL have parameter Y0, default 1, meaning row-parity offset of pixel (0,0); defaults give RGGB.
REQ-006 SHALL have port CLK  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports S_R, S_G, S_B  input  DW each  input RGB pixel.
REQ-009 SHALL have port S_VALID  input  1  input pixel valid.
REQ-010 SHALL have port S_READY  output  1  block accepts input this cycle.
REQ-011 SHALL have port S_SOF  input  1  input pixel is frame pixel (0,0).
REQ-012 SHALL have port S_EOL  input  1  input pixel is the last of its line.
REQ-013 SHALL have port M_DATA  output  DW  mosaiced RAW sample.
REQ-014 SHALL have ports M_X, M_Y  output  1 each  Bayer parity of M_DATA, same encoding the demosaic consumes.
REQ-015 SHALL have ports M_SOF, M_EOL  output  1 each  frame-start / line-end markers aligned to M_DATA.
REQ-016 SHALL have port M_VALID  input-side output  1  output sample valid; M_READY  input  1  downstream accepts.
REQ-017 SHALL have port ERR_SYNC  output  1  sticky sync-error flag.

Function
REQ-018 SHALL transfer input when S_VALID and S_READY are high, and output when M_VALID and M_READY are high.
REQ-019 SHALL drive S_READY = !M_VALID || M_READY (single output register, no combinational path from S_VALID to M_VALID).
REQ-020 SHALL present an accepted pixel on M_* exactly one cycle after acceptance; M_* SHALL hold stable while M_VALID && !M_READY.
REQ-021 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced per accepted pixel in ACTIVE.
REQ-022 SHALL compute x = col[0] ^ X0, y = row[0] ^ Y0 and select {y,x}: 3 -> S_R, 0 -> S_B, 1 or 2 -> S_G.
REQ-023 SHALL have states IDLE and ACTIVE; IDLE accepts and discards pixels without S_SOF (S_READY held per REQ-019, no M_VALID).
REQ-024 SHALL, on accepted S_SOF in any state, treat that pixel as (0,0), emit it with M_SOF=1, and enter ACTIVE.
REQ-025 SHALL set M_EOL=1 on the pixel at col=IMG_W-1, then col wraps to 0 and row increments.
REQ-026 SHALL, after emitting pixel (IMG_W-1, IMG_H-1), return to IDLE.
REQ-027 SHALL set ERR_SYNC when S_EOL disagrees with col=IMG_W-1, or S_SOF arrives in ACTIVE at position other than after frame end.
REQ-028 SHALL, on early S_EOL, emit that pixel with M_EOL=1 and realign col to 0, row+1 (line shortened, not padded).
REQ-029 SHALL, on missing S_EOL at col=IMG_W-1, still wrap per REQ-025 with M_EOL=1 from the internal count.
REQ-030 SHALL give S_SOF precedence over S_EOL when both set; EOL then checked at col=0.
REQ-031 SHALL clear ERR_SYNC only by reset.

Reset
REQ-032 SHALL, while RST_N low at CLK edge, force IDLE, col=0, row=0, M_VALID=0, M_DATA=0, M_X=0, M_Y=0, M_SOF=0, M_EOL=0, ERR_SYNC=0.
REQ-033 SHALL discard any sample held in the output register on reset mid-frame; S_READY=1 the first cycle after reset release.

Structure
REQ-034 SHALL place DW default, Bayer {Y,X} code constants (CODE_B=0, CODE_GB=1, CODE_GR=2, CODE_R=3) and the state typedef in shared package isp_pkg.
REQ-035 SHALL use one sub-module bayer_pos_cnt (col/row counters, parity, EOL check); selection and output register in top.

Verification (IMG_W=4, IMG_H=2, defaults X0=Y0=1, M_READY=1 unless stated)
REQ-036 SHALL cover: 8 pixels R=100,G=200,B=300, SOF on first, EOL on 4th/8th -> M_DATA 100,200,100,200,200,300,200,300; {M_Y,M_X} 3,2,3,2,1,0,1,0; M_SOF on 1st, M_EOL on 4th/8th, IDLE after.
REQ-037 SHALL cover: M_READY low 3 cycles mid-line -> S_READY low, M_DATA frozen, no pixel lost or duplicated.
REQ-038 SHALL cover: 5 pixels before SOF -> no M_VALID, ERR_SYNC stays 0.
REQ-039 SHALL cover: S_EOL on 3rd pixel of line 0 -> M_EOL on 3rd, next pixel {M_Y,M_X}=1, ERR_SYNC=1 sticky.
REQ-040 SHALL cover: RST_N low for 1 cycle after 5th pixel with M_READY=0 -> all outputs 0, stalled sample dropped, next SOF frame correct.
REQ-041 SHALL cover: X0=0, Y0=0 -> first line outputs B,G,B,G (300,200,300,200).
